// File: rtl/lsu_mem_stage.sv
// RV32I load/store memory stage driving a req/gnt/rvalid data port.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses instead of aligning them.
module lsu_mem_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic              ex_is_load,
    input  logic              ex_is_store,
    input  logic [2:0]        ex_funct3,
    input  logic [XLEN-1:0]   ex_addr,
    input  logic [XLEN-1:0]   ex_wdata,
    input  logic [REG_AW-1:0] ex_rd,
    output logic              lsu_busy,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [3:0]        dmem_be,
    output logic [XLEN-1:0]   dmem_addr,
    output logic [XLEN-1:0]   dmem_wdata,
    input  logic              dmem_gnt,
    input  logic              dmem_rvalid,
    input  logic [XLEN-1:0]   dmem_rdata,
`ifdef LSU_MISALIGN_TRAP_EN
    output logic              misalign_err,
`endif
    output logic              wb_valid,
    output logic [REG_AW-1:0] wb_rd,
    output logic [XLEN-1:0]   wb_data
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t            state;
    logic [2:0]        f3_q;
    logic [1:0]        off_q;
    logic [REG_AW-1:0] rd_q;

    logic              is_mem;
    logic              legal;
    logic              go;
    logic [1:0]        off;
    logic [3:0]        be;
    logic [XLEN-1:0]   wdata;
    logic [XLEN-1:0]   shifted;
    logic [XLEN-1:0]   ext;

    assign lsu_busy = (state != IDLE);

    // Stores only have SB/SH/SW; loads add LBU/LHU.
    always_comb begin
        is_mem = ex_valid & (ex_is_load | ex_is_store);
        if (ex_is_store)
            legal = (ex_funct3[2] == 1'b0) && (ex_funct3[1:0] != 2'b11);
        else
            legal = (ex_funct3[1:0] != 2'b11) && (ex_funct3 != 3'b110);
    end

    // Halfword lane uses addr[1] only, word ignores low bits entirely.
    always_comb begin
        off   = ex_addr[1:0];
        be    = 4'b0001 << ex_addr[1:0];
        wdata = {4{ex_wdata[7:0]}};
        case (ex_funct3[1:0])
            2'b00: begin
                off   = ex_addr[1:0];
                be    = 4'b0001 << ex_addr[1:0];
                wdata = {4{ex_wdata[7:0]}};
            end
            2'b01: begin
                off   = {ex_addr[1], 1'b0};
                be    = 4'b0011 << {ex_addr[1], 1'b0};
                wdata = {2{ex_wdata[15:0]}};
            end
            default: begin
                off   = 2'b00;
                be    = 4'b1111;
                wdata = ex_wdata;
            end
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic misal;
    logic trap;
    always_comb begin
        misal = 1'b0;
        case (ex_funct3[1:0])
            2'b01:   misal = ex_addr[0];
            2'b10:   misal = |ex_addr[1:0];
            default: misal = 1'b0;
        endcase
        trap = is_mem & legal & misal;
        go   = is_mem & legal & ~misal;
    end
`else
    assign go = is_mem & legal;
`endif

    always_comb begin
        shifted = dmem_rdata >> {off_q, 3'b000};
        case (f3_q)
            3'b000:  ext = {{24{shifted[7]}}, shifted[7:0]};
            3'b100:  ext = {24'h0, shifted[7:0]};
            3'b001:  ext = {{16{shifted[15]}}, shifted[15:0]};
            3'b101:  ext = {16'h0, shifted[15:0]};
            default: ext = shifted;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_be    <= '0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            f3_q       <= '0;
            off_q      <= '0;
            rd_q       <= '0;
            wb_valid   <= 1'b0;
            wb_rd      <= '0;
            wb_data    <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
            misalign_err <= 1'b0;
`endif
        end else begin
            wb_valid <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            misalign_err <= trap && (state == IDLE);
`endif
            case (state)
                IDLE: begin
                    if (go) begin
                        state      <= REQ;
                        dmem_req   <= 1'b1;
                        dmem_we    <= ex_is_store;
                        dmem_be    <= be;
                        dmem_addr  <= {ex_addr[XLEN-1:2], 2'b00};
                        dmem_wdata <= wdata;
                        f3_q       <= ex_funct3;
                        off_q      <= off;
                        rd_q       <= ex_rd;
                    end
                end
                REQ: begin
                    if (dmem_gnt) begin
                        dmem_req <= 1'b0;
                        state    <= dmem_we ? IDLE : WAIT;
                    end
                end
                WAIT: begin
                    if (dmem_rvalid) begin
                        wb_valid <= 1'b1;
                        wb_rd    <= rd_q;
                        wb_data  <= ext;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Bench for lsu_mem_stage: directed plan steps then random accesses
// checked against a byte-lane reference model.
module tb_lsu_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic        ex_is_load;
    logic        ex_is_store;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_addr;
    logic [31:0] ex_wdata;
    logic [4:0]  ex_rd;
    logic        lsu_busy;
    logic        dmem_req;
    logic        dmem_we;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
`ifdef LSU_MISALIGN_TRAP_EN
    logic        misalign_err;
`endif
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] exp_wb_data;
    logic [4:0]  exp_wb_rd;

    always #5 clk = ~clk;

    lsu_mem_stage dut (
        .clk         (clk),
        .rst         (rst),
        .ex_valid    (ex_valid),
        .ex_is_load  (ex_is_load),
        .ex_is_store (ex_is_store),
        .ex_funct3   (ex_funct3),
        .ex_addr     (ex_addr),
        .ex_wdata    (ex_wdata),
        .ex_rd       (ex_rd),
        .lsu_busy    (lsu_busy),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_be     (dmem_be),
        .dmem_addr   (dmem_addr),
        .dmem_wdata  (dmem_wdata),
        .dmem_gnt    (dmem_gnt),
        .dmem_rvalid (dmem_rvalid),
        .dmem_rdata  (dmem_rdata),
`ifdef LSU_MISALIGN_TRAP_EN
        .misalign_err(misalign_err),
`endif
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference model: sizes in bytes, lanes as byte offsets.
    function automatic int nbytes(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit is_legal(input bit st, input logic [2:0] f3);
        if (st) return f3 <= 3'd2;
        return f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    endfunction

    function automatic int lane_off(input logic [31:0] a, input logic [2:0] f3);
        int o = int'(a % 4);
        return o - (o % nbytes(f3));
    endfunction

    function automatic logic [3:0] model_be(input logic [31:0] a, input logic [2:0] f3);
        int m = ((1 << nbytes(f3)) - 1) << lane_off(a, f3);
        return 4'(m);
    endfunction

    function automatic logic [31:0] model_wd(input logic [31:0] d, input logic [2:0] f3);
        logic [31:0] r;
        int n = nbytes(f3);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_ld(input logic [31:0] rdata,
                                             input logic [31:0] a,
                                             input logic [2:0] f3);
        int n = nbytes(f3);
        logic [31:0] v;
        logic [31:0] m;
        v = rdata >> (8 * lane_off(a, f3));
        m = (n == 4) ? 32'hFFFF_FFFF : (32'(1) << (8 * n)) - 32'd1;
        v = v & m;
        if (!f3[2] && n < 4 && v[8*n-1]) v = v | ~m;
        return v;
    endfunction

    // One complete transaction; entered and left at a negedge with the DUT idle.
    task automatic access(input bit ev, input bit ld, input bit st,
                          input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d, input logic [4:0] rd,
                          input int gw, input int rw, input logic [31:0] rdata);
        bit issue;
        bit trap;
        issue = ev && (ld || st) && is_legal(st, f3);
        trap  = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        trap  = issue && ((a % nbytes(f3)) != 0);
        issue = issue && !trap;
`endif
        ex_valid    = ev;
        ex_is_load  = ld;
        ex_is_store = st;
        ex_funct3   = f3;
        ex_addr     = a;
        ex_wdata    = d;
        ex_rd       = rd;
        @(negedge clk);
        ex_valid    = 1'b0;
        ex_addr     = $urandom;
        ex_wdata    = $urandom;
        if (!issue) begin
            chk("noreq", dmem_req, 0);
            chk("nobusy", lsu_busy, 0);
            chk("nowb", wb_valid, 0);
`ifdef LSU_MISALIGN_TRAP_EN
            chk("misalign_err", misalign_err, trap);
            @(negedge clk);
            chk("misalign_pulse", misalign_err, 0);
            chk("trap_noreq", dmem_req, 0);
`endif
            chk("wb_hold", wb_data, exp_wb_data);
            return;
        end
        for (int i = 0; i <= gw; i++) begin
            chk("req", dmem_req, 1);
            chk("we", dmem_we, st);
            chk("be", dmem_be, model_be(a, f3));
            chk("addr", dmem_addr, {a[31:2], 2'b00});
            if (st) chk("wdata", dmem_wdata, model_wd(d, f3));
            chk("busy", lsu_busy, 1);
            if (i == gw) dmem_gnt = 1'b1;
            @(negedge clk);
            dmem_gnt = 1'b0;
        end
        chk("req_drop", dmem_req, 0);
        if (st) begin
            chk("st_busy", lsu_busy, 0);
            chk("st_nowb", wb_valid, 0);
            chk("wb_hold", wb_data, exp_wb_data);
            return;
        end
        for (int i = 0; i < rw; i++) begin
            chk("wait_busy", lsu_busy, 1);
            chk("wait_nowb", wb_valid, 0);
            @(negedge clk);
        end
        dmem_rvalid = 1'b1;
        dmem_rdata  = rdata;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        dmem_rdata  = $urandom;
        exp_wb_data = model_ld(rdata, a, f3);
        exp_wb_rd   = rd;
        chk("wb_valid", wb_valid, 1);
        chk("wb_rd", wb_rd, exp_wb_rd);
        chk("wb_data", wb_data, exp_wb_data);
        chk("ld_busy", lsu_busy, 0);
        @(negedge clk);
        chk("wb_pulse", wb_valid, 0);
        chk("wb_keep", wb_data, exp_wb_data);
    endtask

    initial begin
        logic [31:0] r;
        rst = 1'b1;
        ex_valid = 1'b0;
        ex_is_load = 1'b0;
        ex_is_store = 1'b0;
        ex_funct3 = 3'd0;
        ex_addr = '0;
        ex_wdata = '0;
        ex_rd = '0;
        dmem_gnt = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata = '0;
        exp_wb_data = '0;
        exp_wb_rd = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_req", dmem_req, 0);
        chk("rst_we", dmem_we, 0);
        chk("rst_be", dmem_be, 0);
        chk("rst_addr", dmem_addr, 0);
        chk("rst_wdata", dmem_wdata, 0);
        chk("rst_busy", lsu_busy, 0);
        chk("rst_wbv", wb_valid, 0);
        chk("rst_wbrd", wb_rd, 0);
        chk("rst_wbdata", wb_data, 0);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("rst_misalign", misalign_err, 0);
`endif

        // Stray rvalid while idle must be ignored.
        rst = 1'b0;
        dmem_rvalid = 1'b1;
        dmem_rdata = 32'h1234_5678;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        chk("idle_rvalid", wb_valid, 0);
        chk("idle_rvalid_busy", lsu_busy, 0);

        access(1, 0, 1, 3'b010, 32'h100, 32'hDEAD_BEEF, 5'd1, 2, 0, 0);
        access(1, 0, 1, 3'b000, 32'h103, 32'h0000_00A5, 5'd2, 0, 0, 0);
        chk("plan_sb_be", dmem_be, 4'b1000);
        chk("plan_sb_wd", dmem_wdata, 32'hA5A5_A5A5);
        access(1, 1, 0, 3'b000, 32'h102, 32'h0, 5'd7, 0, 0, 32'h0080_0000);
        chk("plan_lb", wb_data, 32'hFFFF_FF80);
        chk("plan_lb_rd", wb_rd, 5'd7);
        access(1, 1, 0, 3'b100, 32'h102, 32'h0, 5'd8, 1, 1, 32'h0080_0000);
        chk("plan_lbu", wb_data, 32'h0000_0080);
        access(1, 1, 0, 3'b001, 32'h102, 32'h0, 5'd9, 0, 2, 32'h8001_0000);
        chk("plan_lh", wb_data, 32'hFFFF_8001);
        access(1, 1, 0, 3'b101, 32'h102, 32'h0, 5'd10, 0, 0, 32'h8001_0000);
        chk("plan_lhu", wb_data, 32'h0000_8001);
        access(1, 1, 0, 3'b010, 32'h101, 32'h0, 5'd11, 0, 0, 32'hCAFE_F00D);
        access(1, 0, 0, 3'b010, 32'h200, 32'h0, 5'd12, 0, 0, 0);
        access(1, 1, 0, 3'b011, 32'h200, 32'h0, 5'd13, 0, 0, 0);
        access(1, 0, 1, 3'b100, 32'h200, 32'h55, 5'd14, 0, 0, 0);
        access(1, 1, 1, 3'b000, 32'h201, 32'h3C, 5'd15, 1, 0, 0);

        // Reset while a store waits for grant.
        ex_valid = 1'b1; ex_is_load = 1'b0; ex_is_store = 1'b1;
        ex_funct3 = 3'b010; ex_addr = 32'h300; ex_wdata = 32'h1;
        @(negedge clk);
        ex_valid = 1'b0;
        chk("rreq_req", dmem_req, 1);
        #2 rst = 1'b1;
        #1 chk("rreq_drop", dmem_req, 0);
        chk("rreq_busy", lsu_busy, 0);
        @(negedge clk);
        rst = 1'b0;
        exp_wb_data = '0;
        exp_wb_rd = '0;

        // Reset while a load waits for data; late rvalid discarded.
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_is_store = 1'b0;
        ex_funct3 = 3'b010; ex_addr = 32'h400; ex_rd = 5'd20;
        @(negedge clk);
        ex_valid = 1'b0;
        dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0;
        chk("rwait_busy", lsu_busy, 1);
        #2 rst = 1'b1;
        #1 chk("rwait_req", dmem_req, 0);
        chk("rwait_idle", lsu_busy, 0);
        @(negedge clk);
        rst = 1'b0;
        dmem_rvalid = 1'b1;
        dmem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        chk("rwait_nowb", wb_valid, 0);
        chk("rwait_wbdata", wb_data, 0);
        @(negedge clk);
        chk("rwait_nowb2", wb_valid, 0);
        chk("rwait_busy2", lsu_busy, 0);

        for (int k = 0; k < 200; k++) begin
            r = $urandom;
            access(r[2:0] != 3'd0, r[3], r[4], r[7:5], $urandom, $urandom,
                   r[12:8], int'(r[14:13]), int'(r[16:15] % 3), $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
- Memory-access stage directly downstream of the execute ALU.
- Consumes the ALU result as the effective address and rs2 as store data.
- Drives a req/gnt/rvalid data-memory port and produces byte-lane enables, store-data replication, and sign/zero-extended load data for writeback.
- Multi-cycle; holds the pipeline via lsu_busy while an access is outstanding.

Parameters:
- XLEN, 32, datapath/address width (only 32 supported)
- REG_AW, 5, destination register index width

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous active-high reset
- ex_valid  in  1  execute stage presents an instruction
- ex_is_load  in  1  instruction is a load
- ex_is_store  in  1  instruction is a store
- ex_funct3  in  3  RV32I size/sign field
- ex_addr  in  XLEN  effective address (ALU out)
- ex_wdata  in  XLEN  store data (rs2)
- ex_rd  in  REG_AW  load destination register
- lsu_busy  out  1  stage occupied; upstream must hold
- dmem_req  out  1  memory request
- dmem_we  out  1  1=write
- dmem_be  out  4  byte enables
- dmem_addr  out  XLEN  word-aligned address ({ex_addr[31:2],2'b00})
- dmem_wdata  out  XLEN  lane-replicated store data
- dmem_gnt  in  1  request accepted
- dmem_rvalid  in  1  read data valid
- dmem_rdata  in  XLEN  read data
- wb_valid  out  1  one-cycle load result pulse
- wb_rd  out  REG_AW  load destination
- wb_data  out  XLEN  extended load data

Behaviour:
- Reset: all outputs 0; state IDLE; captured registers cleared.
- FSM: IDLE, REQ, WAIT.
  - IDLE: accept when ex_valid & (ex_is_load | ex_is_store). Capture addr/funct3/data/rd/type; next REQ. Non-memory ex_valid is ignored.
  - If ex_is_load and ex_is_store are both high, the access is a store.
  - REQ: dmem_req=1 with stable addr/we/be/wdata until dmem_gnt.
    - Store: gnt -> IDLE.
    - Load: gnt -> WAIT.
  - WAIT: dmem_req=0; on dmem_rvalid register result -> wb_valid=1 next cycle, state IDLE.
- lsu_busy = (state != IDLE). All dmem_* outputs are registered.
- Latency: accept edge N -> dmem_req high cycle N+1.
  - Zero-wait gnt: store done, busy low at N+2.
  - Load with rvalid at N+2: wb_valid at N+3.
- dmem_rvalid is never expected in the gnt cycle; it is ignored outside WAIT, including after reset.
- Store encoding:
  - SB (000): be=4'b0001<<addr[1:0], wdata={4{d[7:0]}}.
  - SH (001): be=4'b0011<<{addr[1],1'b0}, wdata={2{d[15:0]}}.
  - SW (010): be=4'b1111, wdata=d.
- Load encoding: shift rdata right by 8*addr[1:0], then extend.
  - LB (000) sign from bit 7; LBU (100) zero-extend.
  - LH (001) sign from bit 15; LHU (101) zero-extend.
  - LW (010) unchanged.
  - Loads use be per size as for stores; dmem_we=0.
- Illegal funct3 (011, 110, 111; stores >=011): no memory request. State IDLE -> IDLE, busy low, no wb_valid.
- Misaligned (half addr[0]=1; word addr[1:0]!=0): see Optional Feature.
- wb_valid is a single-cycle pulse. wb_rd/wb_data hold their values until the next load completes.
- Asynchronous reset mid-access: immediate return to IDLE, dmem_req drops without waiting for gnt, pending load result discarded.

Optional Feature:
- Macro LSU_MISALIGN_TRAP_EN.
- Defined:
  - Adds output port misalign_err (1 bit).
  - A misaligned access is not issued. misalign_err pulses one cycle after the accept edge; no wb_valid; FSM stays IDLE.
- Undefined:
  - Port absent.
  - Misaligned address bits are forced aligned: halfword uses addr[1] only, word uses no low bits.
  - Access proceeds normally.

Test Plan:
- SW addr 0x100, data 0xDEADBEEF, gnt after 2 wait cycles -> req held 3 cycles, addr 0x100, be 1111, wdata 0xDEADBEEF, busy low after gnt, no wb_valid.
- SB addr 0x103, data 0x000000A5 -> be 1000, wdata 0xA5A5A5A5, addr 0x100.
- LB addr 0x102, rdata 0x00800000 -> wb_data 0xFFFFFF80. Same with LBU -> 0x00000080. wb_rd matches ex_rd, wb_valid exactly 1 cycle.
- LH addr 0x102, rdata 0x80010000 -> wb_data 0xFFFF8001; LHU -> 0x00008001.
- Assert rst during WAIT, then rvalid 1 cycle later -> dmem_req 0 immediately, wb_valid never asserted, busy 0.
- LW addr 0x101: with LSU_MISALIGN_TRAP_EN -> misalign_err 1 cycle, no dmem_req. Without it -> dmem_req at addr 0x100, be 1111.
